// File: rtl/gpio_pio_bidir.sv
// Avalon-MM bidirectional GPIO port with per-bit direction, input
// synchroniser, edge capture and a maskable level interrupt.
module gpio_pio_bidir #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] dir_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] cap_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rd;
  logic             wr;
  logic             unused_bits;

  assign sync_out    = sync_q[SYNC_STAGES-1];
  assign wd          = writedata[WIDTH-1:0];
  assign wr          = chipselect && !write_n;
  assign oe          = dir_q;
  assign irq         = |(cap_q & mask_q);
  assign unused_bits = ^writedata;

  // Input synchroniser chain plus the previous-value register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_out;
    end
  end

  // Settle counter masks edges caused by pin levels right after reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= CW'(SYNC_STAGES + 1);
    else if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
  end

  // Edge detector selected by EDGE_TYPE, gated while settling.
  always_comb begin
    det = '0;
    if (cnt_q == '0) begin
      case (EDGE_TYPE)
        0:       det = sync_out & ~prev_q;
        1:       det = ~sync_out & prev_q;
        default: det = sync_out ^ prev_q;
      endcase
    end
  end

  // Write-1-to-clear strobe for the capture register.
  always_comb begin
    clr = '0;
    if (wr && address == 3'd3) clr = wd;
  end

  // Bus-writable control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_port <= RESET_VALUE;
      dir_q    <= '0;
      mask_q   <= '0;
    end else if (wr) begin
      unique case (address)
        3'd0:    out_port <= wd;
        3'd1:    dir_q    <= wd;
        3'd2:    mask_q   <= wd;
        default: ;
      endcase
    end
  end

  // Edge capture: a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) cap_q <= '0;
    else cap_q <= (cap_q & ~clr) | det;
  end

  // Read mux; outputs read back from out_port, inputs from the synchroniser.
  always_comb begin
    rd = '0;
    unique case (address)
      3'd0:    rd = (out_port & dir_q) | (sync_out & ~dir_q);
      3'd1:    rd = dir_q;
      3'd2:    rd = mask_q;
      3'd3:    rd = cap_q;
      default: rd = '0;
    endcase
  end

  // Registered read data, one cycle after the address.
  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else readdata <= 32'(rd);
  end

endmodule

// File: tb/tb_gpio_pio_bidir.sv
// Directed self-checking bench for gpio_pio_bidir: default 8-bit port
// plus 32-bit and 1-bit any-edge variants with 3 synchroniser stages.
module tb_gpio_pio_bidir;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  logic [7:0]  in8, out8, oe8;
  logic [31:0] rd8;
  logic        irq8;

  logic [31:0] in32, out32, oe32;
  logic [31:0] rd32;
  logic        irq32;

  logic [0:0]  in1, out1, oe1;
  logic [31:0] rd1;
  logic        irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_pio_bidir #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_VALUE(8'h5A)
  ) u8 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd8),
    .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8)
  );

  gpio_pio_bidir #(
    .WIDTH(32), .SYNC_STAGES(3), .EDGE_TYPE(2), .RESET_VALUE(32'h0)
  ) u32 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd32),
    .in_port(in32), .out_port(out32), .oe(oe32), .irq(irq32)
  );

  gpio_pio_bidir #(
    .WIDTH(1), .SYNC_STAGES(3), .EDGE_TYPE(2), .RESET_VALUE(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1),
    .in_port(in1), .out_port(out1), .oe(oe1), .irq(irq1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a);
    address = a;
    tick();
  endtask

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in8        = 8'hFF;
    in32       = 32'hFFFF_FFFF;
    in1        = 1'b1;

    tick(2);
    chk("rst_rd", rd8, 32'h0);
    chk("rst_oe", 32'(oe8), 32'h0);
    chk("rst_out", 32'(out8), 32'h5A);
    chk("rst_irq", 32'(irq8), 32'h0);
    reset = 1'b0;

    tick(6);
    rd_reg(3'd3);
    chk("settle_edge8", rd8, 32'h0);
    chk("settle_edge32", rd32, 32'h0);
    chk("settle_edge1", rd1, 32'h0);

    wr_reg(3'd1, 32'h0F);
    chk("dir_oe", 32'(oe8), 32'h0F);
    wr_reg(3'd0, 32'hA5);
    chk("data_out", 32'(out8), 32'hA5);
    rd_reg(3'd1);
    chk("dir_rd", rd8, 32'h0F);
    in8 = 8'h30;
    tick(3);
    rd_reg(3'd0);
    chk("data_mix", rd8, 32'h35);
    chk("data_mix32", rd32, 32'hFFFF_FFF5);

    wr_reg(3'd2, 32'h01);
    in8 = 8'h31;
    tick(2);
    chk("rise_early_irq", 32'(irq8), 32'h0);
    tick();
    chk("rise_irq", 32'(irq8), 32'h1);
    rd_reg(3'd3);
    chk("rise_edge", rd8, 32'h01);
    in8 = 8'h30;
    tick(4);
    rd_reg(3'd3);
    chk("fall_ignored", rd8, 32'h01);

    in8 = 8'h32;
    tick(3);
    rd_reg(3'd3);
    chk("edge_03", rd8, 32'h03);
    wr_reg(3'd3, 32'h01);
    rd_reg(3'd3);
    chk("w1c", rd8, 32'h02);
    in8 = 8'h30;
    tick(4);
    in8 = 8'h32;
    tick(2);
    wr_reg(3'd3, 32'h02);
    rd_reg(3'd3);
    chk("set_wins", rd8, 32'h02);

    wr_reg(3'd3, 32'hFF);
    wr_reg(3'd2, 32'h00);
    in8 = 8'h34;
    tick(3);
    rd_reg(3'd3);
    chk("edge_04", rd8, 32'h04);
    chk("mask0_irq", 32'(irq8), 32'h0);
    wr_reg(3'd2, 32'h04);
    chk("mask_irq", 32'(irq8), 32'h1);
    wr_reg(3'd3, 32'h04);
    chk("clr_irq", 32'(irq8), 32'h0);

    wr_reg(3'd2, 32'h8000_0001);
    in32 = 32'h7FFF_FFFF;
    tick(3);
    chk("w32_early_irq", 32'(irq32), 32'h0);
    tick();
    chk("w32_fall_irq", 32'(irq32), 32'h1);
    rd_reg(3'd3);
    chk("w32_fall_edge", rd32, 32'h8000_0000);
    wr_reg(3'd3, 32'h8000_0000);
    rd_reg(3'd3);
    chk("w32_clr", rd32, 32'h0);
    in32 = 32'hFFFF_FFFF;
    tick(4);
    rd_reg(3'd3);
    chk("w32_rise_edge", rd32, 32'h8000_0000);

    in1 = 1'b0;
    tick(3);
    chk("w1_early_irq", 32'(irq1), 32'h0);
    tick();
    chk("w1_fall_irq", 32'(irq1), 32'h1);
    wr_reg(3'd3, 32'h1);
    in1 = 1'b1;
    tick(4);
    rd_reg(3'd3);
    chk("w1_rise_edge", rd1, 32'h1);

    wr_reg(3'd4, 32'hFFFF_FFFF);
    for (int a = 4; a < 8; a++) begin
      rd_reg(3'(a));
      chk($sformatf("hi_rd8_%0d", a), rd8, 32'h0);
      chk($sformatf("hi_rd32_%0d", a), rd32, 32'h0);
      chk($sformatf("hi_rd1_%0d", a), rd1, 32'h0);
    end
    rd_reg(3'd1);
    chk("hi_wr_ign", rd8, 32'h0F);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_out", 32'(out8), 32'h5A);
    chk("mid_rst_oe", 32'(oe8), 32'h0);
    chk("mid_rst_irq1", 32'(irq1), 32'h0);
    chk("mid_rst_rd", rd32, 32'h0);
    tick(6);
    rd_reg(3'd3);
    chk("mid_rst_edge1", rd1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_pio_bidir.md
# gpio_pio_bidir

Parametrised Avalon-MM general-purpose I/O port that supersedes the fixed 8-bit input-only PIO in the sub-system. It provides up to 32 bidirectional pins with per-bit direction control, a metastability synchroniser on inputs, edge capture with selectable edge type, and a maskable level interrupt. It sits on the sub-system's Avalon bus next to the other PIOs and drives board-level pins through `out_port`/`oe`.

## Interface
- `WIDTH`, 8: number of pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.
- `EDGE_TYPE`, 0: 0 = rising, 1 = falling, 2 = any edge.
- `RESET_VALUE`, 0: reset value of the output data register (`WIDTH` bits).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select; qualifies writes only.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data; bits above `WIDTH` are ignored.
- `readdata`  out  32  registered read data, zero-extended above `WIDTH`.
- `in_port`  in  WIDTH  asynchronous pin inputs.
- `out_port`  out  WIDTH  output data register.
- `oe`  out  WIDTH  per-bit output enable (= direction register).
- `irq`  out  1  level interrupt.

## Operation
- Write occurs when `chipselect && !write_n` at a clock edge.
- Register map:
  - 0 DATA: write loads `out_port`. Read returns, per bit, `out_port` where `dir`=1, else synchronised input.
  - 1 DIR: 1 = output. Read returns DIR.
  - 2 MASK: interrupt mask. Read returns MASK.
  - 3 EDGE: read returns the capture register. A write clears every bit written as 1 (write-1-to-clear).
  - 4–7: reads return 0; writes are ignored.
- Synchroniser: a `SYNC_STAGES`-deep flop chain per bit, plus a `prev` register holding the last synchroniser output.
- Edge detection: per bit, from the synchroniser output vs. `prev`, according to `EDGE_TYPE`. Detection runs on all bits regardless of DIR.
- Settle counter: loaded with `SYNC_STAGES+1` on reset and decrements to 0. While it is nonzero, edge detection is forced to 0, so no spurious captures occur from post-reset pin levels.
- Capture bit: set on a detected edge. It holds until cleared by a write-1. If a set and a clear hit the same bit in the same cycle, the set wins.
- `irq` = OR over (EDGE & MASK), driven from registers with no combinational path from bus inputs.

## Timing
- Reset values:
  - `readdata` = 0, `out_port` = `RESET_VALUE`, `oe`/DIR = 0, MASK = 0, EDGE = 0, `irq` = 0.
  - Synchroniser chain and `prev` = 0.
  - Settle counter = `SYNC_STAGES+1`.
- Read latency: `readdata` is updated every cycle from `address`, so data is valid on the edge after the address is presented (fixed latency 1). `chipselect` is not required for reads.
- Write effect: the register and its output (`out_port`, `oe`) update on the write edge. A read of the same address on the next cycle returns the new value.
- Input path, with a pin change first sampled at edge k:
  - The synchronised value is visible in DATA reads issued at edge k+`SYNC_STAGES`.
  - The EDGE bit sets at edge k+`SYNC_STAGES`, and `irq` rises in the same cycle if the bit is masked in.
- MASK write: `irq` reflects the new mask immediately after the write edge.
- `reset` asserted mid-operation: all state returns to its reset values on that edge, including pending captures, which are lost.
- Pulses shorter than one `clk` period may be missed. This is not an error condition.

## Test plan
- Reset/defaults: assert `reset` 2 cycles with `in_port`=8'hFF. Required: `readdata`=0, `oe`=0, `out_port`=`RESET_VALUE`. EDGE reads 0 after the settle period; no spurious capture.
- Output path: write DIR=8'h0F, then DATA=8'hA5. Required: `out_port`=8'hA5, `oe`=8'h0F. With `in_port`=8'h30, a DATA read returns 8'h35 one cycle after the address.
- Rising-edge capture (`EDGE_TYPE`=0, MASK=8'h01): drive `in_port[0]` 0→1 at edge k. Required: EDGE=8'h01 and `irq`=1 at edge k+2. A 1→0 transition leaves EDGE unchanged.
- W1C and collision: with EDGE=8'h03, write 8'h01 to EDGE. Required: EDGE=8'h02. Then issue a clear of bit 1 in the same cycle its new edge is detected. Required: bit 1 stays 1.
- Mask/irq: with EDGE=8'h04 and MASK=0, `irq`=0. Write MASK=8'h04. Required: `irq`=1 the next cycle. Clear EDGE bit 2. Required: `irq`=0 the next cycle.
- Parameter sweep: `WIDTH`=1/32, `SYNC_STAGES`=3, `EDGE_TYPE`=2. Required: both edge directions capture, the latency scales to k+3, and reads of addresses 4–7 return 0.
